// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
// MEM_ARB_RR_EN (optional) enables round-robin fill arbitration in mem_arb_grant.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    localparam logic [15:0] BLK_MASK = 16'hFFF0;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational request pick: store first, then a D/I fill.
// MEM_ARB_RR_EN defined: ties between misses alternate using last_owner_i.
module mem_arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  owner_e last_owner_i,
`endif
    input  logic   wr_req_i,
    input  logic   dc_miss_i,
    input  logic   ic_miss_i,
    output logic   wr_gnt_o,
    output logic   fill_gnt_o,
    output owner_e owner_o
);

    always_comb begin
        wr_gnt_o   = wr_req_i;
        fill_gnt_o = !wr_req_i && (dc_miss_i || ic_miss_i);
        owner_o    = OWN_DC;
`ifdef MEM_ARB_RR_EN
        if (dc_miss_i && ic_miss_i) begin
            owner_o = (last_owner_i == OWN_DC) ? OWN_IC : OWN_DC;
        end else if (ic_miss_i) begin
            owner_o = OWN_IC;
        end
`else
        if (!dc_miss_i && ic_miss_i) begin
            owner_o = OWN_IC;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: write-through stores and pipelined 8-word cache fills.
// MEM_ARB_RR_EN (optional) alternates fill priority between D and I misses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLK = 8,
    parameter int unsigned MEM_LAT       = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        dc_wr_req,
    input  logic [15:0] dc_wr_addr,
    input  logic [15:0] dc_wr_data,
    input  logic        dc_miss,
    input  logic [15:0] dc_miss_addr,
    input  logic        ic_miss,
    input  logic [15:0] ic_miss_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_idx,
    output logic        ic_fill_we,
    output logic        dc_fill_we,
    output logic        ic_fill_done,
    output logic        dc_fill_done,
    output logic        dc_wr_ack,
    output logic        busy
);

    localparam int unsigned       CNT_W     = $clog2(WORDS_PER_BLK) + 1;
    localparam logic [CNT_W-1:0]  BLK_WORDS = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);
    localparam logic [CNT_W-1:0]  LAT_C     = CNT_W'(MEM_LAT);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [15:0]        base_q, base_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   recv_cnt_q, recv_cnt_d;

    logic               wr_gnt;
    logic               fill_gnt;
    owner_e             gnt_owner;
    logic               fill_beat;

`ifdef MEM_ARB_RR_EN
    owner_e             last_owner_q, last_owner_d;

    assign last_owner_d = (state_q == DONE) ? owner_q : last_owner_q;
`endif

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .last_owner_i (last_owner_q),
`endif
        .wr_req_i     (dc_wr_req),
        .dc_miss_i    (dc_miss),
        .ic_miss_i    (ic_miss),
        .wr_gnt_o     (wr_gnt),
        .fill_gnt_o   (fill_gnt),
        .owner_o      (gnt_owner)
    );

    // Returns outside FILL or beyond the block are stale and dropped here.
    assign fill_beat = (state_q == FILL) && mem_valid && (recv_cnt_q < BLK_WORDS);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        fill_data    = '0;
        fill_idx     = '0;
        ic_fill_we   = 1'b0;
        dc_fill_we   = 1'b0;
        ic_fill_done = 1'b0;
        dc_fill_done = 1'b0;
        dc_wr_ack    = 1'b0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (wr_gnt) begin
                    state_d = WRITE;
                end else if (fill_gnt) begin
                    state_d     = FILL;
                    owner_d     = gnt_owner;
                    base_d      = ((gnt_owner == OWN_DC) ? dc_miss_addr : ic_miss_addr) & BLK_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = dc_wr_addr;
                mem_wdata = dc_wr_data;
                dc_wr_ack = 1'b1;
                state_d   = IDLE;
            end
            FILL: begin
                if (issue_cnt_q < BLK_WORDS) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + 16'({issue_cnt_q[CNT_W-2:0], 1'b0});
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (fill_beat) begin
                    fill_data  = mem_rdata;
                    fill_idx   = recv_cnt_q[2:0];
                    ic_fill_we = (owner_q == OWN_IC);
                    dc_fill_we = (owner_q == OWN_DC);
                    recv_cnt_d = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ic_fill_done = (owner_q == OWN_IC);
                dc_fill_done = (owner_q == OWN_DC);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_DC;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_IC;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ic_fill_we || dc_fill_we) || (state_q == FILL && recv_cnt_q < BLK_WORDS))
                else $error("fill write enable raised outside an active fill");
            assert (!(state_q == FILL && mem_valid && recv_cnt_q == '0 && issue_cnt_q < LAT_C))
                else $error("memory returned data before its latency elapsed");
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a fixed-latency memory model.
// Honours MEM_ARB_RR_EN for the expected order of the second miss tie.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dc_wr_req;
    logic [15:0] dc_wr_addr;
    logic [15:0] dc_wr_data;
    logic        dc_miss;
    logic [15:0] dc_miss_addr;
    logic        ic_miss;
    logic [15:0] ic_miss_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        ic_fill_we;
    logic        dc_fill_we;
    logic        ic_fill_done;
    logic        dc_fill_done;
    logic        dc_wr_ack;
    logic        busy;

    logic [58:0] outs;
    assign outs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                   ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack, busy};

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS_PER_BLK(8), .MEM_LAT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .dc_wr_req    (dc_wr_req),
        .dc_wr_addr   (dc_wr_addr),
        .dc_wr_data   (dc_wr_data),
        .dc_miss      (dc_miss),
        .dc_miss_addr (dc_miss_addr),
        .ic_miss      (ic_miss),
        .ic_miss_addr (ic_miss_addr),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .fill_data    (fill_data),
        .fill_idx     (fill_idx),
        .ic_fill_we   (ic_fill_we),
        .dc_fill_we   (dc_fill_we),
        .ic_fill_done (ic_fill_done),
        .dc_fill_done (dc_fill_done),
        .dc_wr_ack    (dc_wr_ack),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rd_seen = 0, wr_seen = 0, ack_cnt = 0, fill_we_cnt = 0, valid_cnt = 0;
    int ic_done_cnt = 0, dc_done_cnt = 0;
    int fill_start = 0, last_wr_cyc = 0, prev_wr_cyc = 0;

    logic [32:0] exp_mem[$];    // {wr, addr, wdata}
    logic [20:0] exp_fill[$];   // {ic_we, dc_we, idx, data}
    logic        exp_done[$];   // 1 = I-cache fill
    logic [31:0] st_q[$];       // follow-on stores {addr, data}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mdat(input logic [15:0] a);
        return a ^ 16'hC35A;
    endfunction

    task automatic push_fill(input logic is_ic, input logic [15:0] addr, input int unsigned nwords,
                             input int unsigned nfill, input logic with_done);
        logic [15:0] b;
        logic [15:0] a;
        b = addr & 16'hFFF0;
        for (int unsigned i = 0; i < nwords; i++) begin
            a = b + 16'(i * 2);
            exp_mem.push_back({1'b0, a, 16'h0000});
            if (i < nfill) exp_fill.push_back({is_ic, !is_ic, 3'(i), mdat(a)});
        end
        if (with_done) exp_done.push_back(is_ic);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        for (int unsigned t = 0; t < budget; t++) begin
            step();
            if (!busy && !ic_miss && !dc_miss && !dc_wr_req) break;
        end
        chk(tag, {busy, ic_miss, dc_miss, dc_wr_req}, 4'b0000);
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, exp_mem.size() + exp_fill.size() + exp_done.size(), 0);
    endtask

    // Cycle counter and fixed-latency memory: a read seen in cycle k returns in cycle k+4.
    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin : mem_model
        logic [16:0] pipe [4];
        logic [16:0] req;
        for (int i = 0; i < 4; i++) pipe[i] = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            req = {mem_en === 1'b1 && mem_wr === 1'b0, mem_addr};
            @(posedge clk);
            #1;
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = req;
            mem_valid = pipe[3][16];
            mem_rdata = pipe[3][16] ? mdat(pipe[3][15:0]) : 16'h0000;
        end
    end

    // Scoreboard monitor; also plays the caches by dropping requests on completion.
    initial begin : monitor
        logic d;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (mem_valid) valid_cnt++;
            if (mem_en) begin
                if (exp_mem.size() == 0) chk("mem_unexpected", exp_mem.size(), 1);
                else chk("mem_req", {mem_wr, mem_addr, mem_wdata}, exp_mem.pop_front());
                if (mem_wr) begin
                    prev_wr_cyc = last_wr_cyc;
                    last_wr_cyc = cyc;
                    wr_seen++;
                end else begin
                    rd_seen++;
                    if (mem_addr[3:0] == 4'h0) fill_start = cyc;
                end
            end
            if (ic_fill_we || dc_fill_we) begin
                fill_we_cnt++;
                if (exp_fill.size() == 0) chk("fill_unexpected", exp_fill.size(), 1);
                else chk("fill_word", {ic_fill_we, dc_fill_we, fill_idx, fill_data}, exp_fill.pop_front());
            end
            if (ic_fill_done || dc_fill_done) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", exp_done.size(), 1);
                end else begin
                    d = exp_done.pop_front();
                    chk("done_owner", {ic_fill_done, dc_fill_done}, {d, !d});
                end
                chk("fill_latency", cyc - fill_start, 12);
                if (ic_fill_done) begin ic_done_cnt++; ic_miss = 1'b0; end
                if (dc_fill_done) begin dc_done_cnt++; dc_miss = 1'b0; end
            end
            if (dc_wr_ack || (mem_en && mem_wr)) begin
                chk("ack_with_write", {dc_wr_ack, mem_en & mem_wr}, 2'b11);
                if (dc_wr_ack) begin
                    ack_cnt++;
                    if (st_q.size() != 0) {dc_wr_addr, dc_wr_data} = st_q.pop_front();
                    else dc_wr_req = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0, v0, w0, a0;
        rst = 1'b1;
        dc_wr_req = 1'b0; dc_wr_addr = '0; dc_wr_data = '0;
        dc_miss = 1'b0; dc_miss_addr = '0;
        ic_miss = 1'b0; ic_miss_addr = '0;
        repeat (3) step();
        chk("reset_outputs", outs, '0);
        rst = 1'b0;
        step();

        // Reset in the middle of a D fill; only word 0 returns before the reset.
        push_fill(1'b0, 16'h1234, 5, 1, 1'b0);
        dc_miss_addr = 16'h1234;
        dc_miss = 1'b1;
        for (int t = 0; t < 40 && rd_seen < 5; t++) step();
        chk("reads_before_reset", rd_seen, 5);
        rst = 1'b1;
        dc_miss = 1'b0;
        step();
        chk("rst_midfill_outputs", outs, '0);
        rst = 1'b0;
        v0 = valid_cnt;
        c0 = fill_we_cnt;
        repeat (8) step();
        chk("stale_valids", valid_cnt - v0, 3);
        chk("stale_fill_we", fill_we_cnt - c0, 0);
        chk_drained("reset_drained");

        // Single I miss.
        c0 = ic_done_cnt;
        push_fill(1'b1, 16'h00A6, 8, 8, 1'b1);
        ic_miss_addr = 16'h00A6;
        ic_miss = 1'b1;
        wait_idle("imiss_idle", 60);
        chk("imiss_done_cnt", ic_done_cnt - c0, 1);
        chk_drained("imiss_drained");

        // Simultaneous misses: D side first.
        push_fill(1'b0, 16'h2000, 8, 8, 1'b1);
        push_fill(1'b1, 16'h0040, 8, 8, 1'b1);
        dc_miss_addr = 16'h2000; ic_miss_addr = 16'h0040;
        dc_miss = 1'b1; ic_miss = 1'b1;
        wait_idle("tie1_idle", 100);
        chk_drained("tie1_drained");

        // D-only fill, then a second tie.
        push_fill(1'b0, 16'h4008, 8, 8, 1'b1);
        dc_miss_addr = 16'h4008;
        dc_miss = 1'b1;
        wait_idle("dfill_idle", 60);
        chk_drained("dfill_drained");
`ifdef MEM_ARB_RR_EN
        push_fill(1'b1, 16'h0060, 8, 8, 1'b1);
        push_fill(1'b0, 16'h5000, 8, 8, 1'b1);
`else
        push_fill(1'b0, 16'h5000, 8, 8, 1'b1);
        push_fill(1'b1, 16'h0060, 8, 8, 1'b1);
`endif
        dc_miss_addr = 16'h5000; ic_miss_addr = 16'h0060;
        dc_miss = 1'b1; ic_miss = 1'b1;
        wait_idle("tie2_idle", 100);
        chk_drained("tie2_drained");

        // Store raised in the middle of an I fill waits for DONE.
        c0 = ic_done_cnt;
        push_fill(1'b1, 16'h0100, 8, 8, 1'b1);
        ic_miss_addr = 16'h0100;
        ic_miss = 1'b1;
        v0 = rd_seen;
        for (int t = 0; t < 40 && rd_seen < v0 + 3; t++) step();
        exp_mem.push_back({1'b1, 16'h3000, 16'hBEEF});
        w0 = wr_seen;
        a0 = ack_cnt;
        dc_wr_addr = 16'h3000; dc_wr_data = 16'hBEEF;
        dc_wr_req = 1'b1;
        for (int t = 0; t < 40 && ic_done_cnt == c0; t++) step();
        chk("write_held_off", wr_seen - w0, 0);
        wait_idle("store_idle", 20);
        chk("store_ack_cnt", ack_cnt - a0, 1);
        chk_drained("store_drained");

        // Back-to-back stores with the request held high.
        a0 = ack_cnt;
        exp_mem.push_back({1'b1, 16'h0010, 16'h1111});
        exp_mem.push_back({1'b1, 16'h0012, 16'h2222});
        st_q.push_back({16'h0012, 16'h2222});
        dc_wr_addr = 16'h0010; dc_wr_data = 16'h1111;
        dc_wr_req = 1'b1;
        wait_idle("b2b_idle", 20);
        chk("b2b_acks", ack_cnt - a0, 2);
        chk("b2b_spacing", last_wr_cyc - prev_wr_cyc, 2);
        chk_drained("b2b_drained");

        // Block at the top of the address space stays within its block.
        push_fill(1'b1, 16'hFFFE, 8, 8, 1'b1);
        ic_miss_addr = 16'hFFFE;
        ic_miss = 1'b1;
        wait_idle("wrap_idle", 60);
        chk_drained("wrap_drained");

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
